router_out_reader: RTL and testbench
====================================

ROUTER_OUT_READER -- requirements
Module: router_out_reader

Interface
REQ-001 Parameter START_DELAY, default 2, cycles from valid_out rise to first read_enb; legal 0..20.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 valid_out  input  1  router output FIFO non-empty.
REQ-005 data_out  input  8  router FIFO read data, valid the cycle after read_enb high.
REQ-006 sft_rst  input  1  router soft reset for this port; FIFO contents discarded.
REQ-007 sink_ready  input  1  downstream accepts a byte next cycle.
REQ-008 read_enb  output  1  FIFO read request.
REQ-009 pkt_data  output  8  received byte (equals data_out).
REQ-010 pkt_valid  output  1  pkt_data valid this cycle.
REQ-011 pkt_sop / pkt_eop  output  1 each  marks header byte / parity byte.
REQ-012 pkt_done  output  1  one-cycle pulse, packet complete.
REQ-013 parity_err  output  1  valid with pkt_done; computed parity mismatched.
REQ-014 pkt_abort  output  1  one-cycle pulse, packet dropped by sft_rst.
REQ-015 pkt_cnt, err_cnt  output  8 each  saturating counts of pkt_done and parity_err.

Function
REQ-016 Packet = header {len[7:2], addr[1:0]}, len payload bytes, one parity byte; len 0 legal (header + parity only).
REQ-017 FSM states IDLE, DELAY, RD_HDR, HDR_WAIT, RD_BODY, CHECK.
REQ-018 IDLE -> DELAY on valid_out=1; DELAY counts START_DELAY cycles (START_DELAY=0 bypasses to RD_HDR next cycle).
REQ-019 Read issue condition: read_enb = state in {RD_HDR, RD_BODY} and valid_out and sink_ready.
REQ-020 RD_HDR: one read issued -> HDR_WAIT; HDR_WAIT (read_enb low) captures header, loads remaining = len+1 -> RD_BODY.
REQ-021 RD_BODY: each issued read decrements remaining; after last read -> CHECK.
REQ-022 pkt_valid = read_enb delayed one cycle; pkt_sop on header byte, pkt_eop on parity byte.
REQ-023 Running XOR over header and payload; CHECK compares with parity byte, pulses pkt_done and sets parity_err, -> IDLE.
REQ-024 valid_out or sink_ready low mid-packet: read_enb held low, state/counters held, no byte lost or duplicated.
REQ-025 sft_rst=1 in any non-IDLE state: next state IDLE, read_enb low same cycle, XOR and remaining cleared, pkt_abort pulse, no pkt_done, in-flight byte suppressed (pkt_valid low).
REQ-026 sft_rst=1 in IDLE: no effect, no pkt_abort.
REQ-027 Back-to-back packets: CHECK -> IDLE -> DELAY applies again; no read of next header before pkt_done.
REQ-028 pkt_cnt/err_cnt saturate at 255, never wrap.
REQ-029 Read latency 1: read_enb at cycle t -> pkt_valid/pkt_data at t+1.

Reset
REQ-030 rst=0 at clk edge: state IDLE; read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, pkt_abort = 0; pkt_cnt, err_cnt, XOR, remaining, delay counter = 0.
REQ-031 Reset mid-packet: no pkt_done or pkt_abort emitted.

Structure
REQ-032 Shared router package holds FSM state encoding, header field positions (len [7:2], addr [1:0]), timeout limit 30.
REQ-033 START_DELAY + max stall tolerance documented below 29 cycles of read_enb low while valid_out high.
REQ-034 One sub-module natural: router_parity_acc (clear, enable, byte in, running XOR out).

Verification
REQ-035 Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 8'h0C^11^22^33=8'h0C: pkt_done, parity_err=0, pkt_cnt=1, four read_enb cycles after one bubble.
REQ-036 Same packet, parity 8'hFF: pkt_done with parity_err=1, err_cnt=1.
REQ-037 Header 8'h01 (len 0), parity 8'h01: two bytes read, sop then eop, parity_err=0.
REQ-038 len 5, sink_ready low for 10 cycles after byte 2: read_enb low 10 cycles, all 7 bytes delivered in order once.
REQ-039 sft_rst pulse after byte 2 of len-10 packet: pkt_abort=1 one cycle, no pkt_done, state IDLE, pkt_cnt unchanged.
REQ-040 300 good packets: pkt_cnt holds 255.

Source files
------------

// File: rtl/router_out_reader_pkg.sv
// Shared definitions for the router output-port reader.
//   state_t        : reader FSM state encoding
//   HDR_* fields   : header byte layout, len in [7:2], addr in [1:0]
//   TIMEOUT_LIMIT  : the router drops a port whose read_enb stays low for this
//                    many cycles while valid_out is high. START_DELAY plus the
//                    longest sink_ready stall must stay below 29 cycles.
//   hdr_len()      : extract payload length from a header byte
//   sat_inc8()     : 8-bit increment that sticks at 255
package router_out_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_RD_HDR   = 3'd2,
    ST_HDR_WAIT = 3'd3,
    ST_RD_BODY  = 3'd4,
    ST_CHECK    = 3'd5
  } state_t;

  localparam int HDR_LEN_MSB     = 7;
  localparam int HDR_LEN_LSB     = 2;
  localparam int HDR_ADDR_MSB    = 1;
  localparam int HDR_ADDR_LSB    = 0;
  localparam int TIMEOUT_LIMIT   = 30;
  localparam int MAX_START_DELAY = 20;

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/router_out_reader_parity_acc.sv
// router_parity_acc: running XOR of the bytes of one packet.
//   clk, rst : clock, synchronous active-low reset
//   clear    : zero the accumulator (wins over enable)
//   enable   : fold din into the accumulator this cycle
//   din      : byte to accumulate
//   acc      : running XOR
module router_parity_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      acc <= 8'h00;
    end else if (enable) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/router_out_reader.sv
// router_out_reader: drains one router output FIFO one packet at a time,
// forwards each byte with sop/eop marks and checks the trailing parity byte.
//   clk, rst        : clock, synchronous active-low reset
//   valid_out       : router FIFO non-empty
//   data_out        : FIFO read data, valid the cycle after read_enb
//   sft_rst         : router soft reset of this port, drops the current packet
//   sink_ready      : downstream can take a byte next cycle
//   read_enb        : FIFO read request (combinational)
//   pkt_data        : received byte, pkt_valid qualifies it
//   pkt_sop/pkt_eop : header byte / parity byte marks
//   pkt_done        : one-cycle pulse per completed packet, parity_err with it
//   pkt_abort       : one-cycle pulse per packet dropped by sft_rst
//   pkt_cnt/err_cnt : saturating counts of pkt_done / parity_err
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for valid_out
// DELAY     | counting START_DELAY cycles before the header read
// RD_HDR    | issuing the header read
// HDR_WAIT  | header byte on data_out, load remaining = len + 1
// RD_BODY   | issuing payload and parity reads
// CHECK     | parity byte on data_out, compare and report
module router_out_reader #(
  parameter int START_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_out,
  input  logic [7:0] data_out,
  input  logic       sft_rst,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic [7:0] pkt_cnt,
  output logic [7:0] err_cnt
);
  import router_out_reader_pkg::*;

  state_t      state;
  logic [4:0]  delay_cnt;
  logic [6:0]  remaining;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic [7:0]  parity_acc;
  logic        abort_now;
  logic        acc_clear;
  logic        acc_enable;

  assign abort_now = sft_rst && (state != ST_IDLE);

  assign read_enb = ((state == ST_RD_HDR) || (state == ST_RD_BODY)) &&
                    valid_out && sink_ready && !sft_rst;

  // The byte returned for a read issued last cycle is dropped when the
  // packet is being aborted this cycle.
  assign pkt_data  = data_out;
  assign pkt_valid = valid_q && !sft_rst;
  assign pkt_sop   = sop_q && !sft_rst;
  assign pkt_eop   = eop_q && !sft_rst;

  // Header and payload go into the XOR; the parity byte itself does not.
  assign acc_clear  = abort_now || (state == ST_IDLE) || (state == ST_CHECK);
  assign acc_enable = valid_q && !eop_q;

  router_parity_acc u_parity_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .enable (acc_enable),
    .din    (data_out),
    .acc    (parity_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      delay_cnt  <= 5'd0;
      remaining  <= 7'd0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_cnt    <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      valid_q    <= read_enb;
      sop_q      <= read_enb && (state == ST_RD_HDR);
      eop_q      <= read_enb && (state == ST_RD_BODY) && (remaining == 7'd1);
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;

      if (abort_now) begin
        state     <= ST_IDLE;
        delay_cnt <= 5'd0;
        remaining <= 7'd0;
        pkt_abort <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (valid_out) begin
              if (START_DELAY == 0) begin
                state <= ST_RD_HDR;
              end else begin
                delay_cnt <= 5'(START_DELAY);
                state     <= ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (delay_cnt == 5'd1) begin
              delay_cnt <= 5'd0;
              state     <= ST_RD_HDR;
            end else begin
              delay_cnt <= delay_cnt - 5'd1;
            end
          end
          ST_RD_HDR: begin
            if (read_enb) begin
              state <= ST_HDR_WAIT;
            end
          end
          ST_HDR_WAIT: begin
            // payload bytes plus the parity byte
            remaining <= 7'(hdr_len(data_out)) + 7'd1;
            state     <= ST_RD_BODY;
          end
          ST_RD_BODY: begin
            if (read_enb) begin
              remaining <= remaining - 7'd1;
              if (remaining == 7'd1) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            pkt_done   <= 1'b1;
            parity_err <= (parity_acc != data_out);
            pkt_cnt    <= sat_inc8(pkt_cnt);
            if (parity_acc != data_out) begin
              err_cnt <= sat_inc8(err_cnt);
            end
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader. The bench plays the router FIFO (a byte queue)
// and keeps a packet-level model: byte order, sop/eop position from the header
// length, XOR parity, done/abort pulses and saturating counters.
module tb_router_out_reader;

  localparam int SD = 2;

  logic       clk;
  logic       rst;
  logic       valid_out;
  logic [7:0] data_out;
  logic       sft_rst;
  logic       sink_ready;
  logic       read_enb;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_abort;
  logic [7:0] pkt_cnt;
  logic [7:0] err_cnt;

  router_out_reader #(.START_DELAY(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .sft_rst    (sft_rst),
    .sink_ready (sink_ready),
    .read_enb   (read_enb),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .pkt_abort  (pkt_abort),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // stimulus controls
  bit rst_req, sft_req, sr_low;
  int gate_pct, sr_pct;

  // router FIFO and model state
  logic [7:0] fifo[$];
  logic [7:0] last_pop;
  logic [7:0] xacc;
  bit   exp_valid, exp_done, exp_err_v, exp_abort, done_pend, err_pend;
  bit   bubble, no_read;
  int   pos, cur_len, rd_pos, rd_total;
  int   exp_pkt, exp_errc;
  int   cycle, last_idle_cycle;
  int   n_valid, n_done, n_abort, done_cycle;
  bit   last_err;
  int   rd_cycles[$];

  int t2_off[5] = '{3, 5, 6, 7, 8};
  int t4_off[2] = '{3, 5};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cycle);
    end
  endtask

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic compare();
    bit ev, es, ee;
    ev = exp_valid && !sft_rst;
    chk("pkt_valid", pkt_valid, ev);
    if (ev) begin
      chk("pkt_data", pkt_data, last_pop);
      es = (pos == 0);
      ee = (pos != 0) && (pos == cur_len + 1);
      chk("pkt_sop", pkt_sop, es);
      chk("pkt_eop", pkt_eop, ee);
      n_valid++;
      if (es) begin
        cur_len  = int'(last_pop[7:2]);
        rd_total = cur_len + 2;
        xacc     = last_pop;
        pos      = 1;
      end else if (ee) begin
        done_pend = 1;
        err_pend  = (xacc != last_pop);
        pos       = 0;
      end else begin
        xacc = xacc ^ last_pop;
        pos++;
      end
    end else begin
      chk("sop_eop_quiet", {pkt_sop, pkt_eop}, 2'b00);
    end
    chk("pkt_done", pkt_done, exp_done);
    chk("parity_err", parity_err, exp_done ? exp_err_v : 1'b0);
    chk("pkt_abort", pkt_abort, exp_abort);
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("err_cnt", err_cnt, exp_errc);
    if (pkt_done) begin
      n_done++;
      done_cycle = cycle;
      last_err   = parity_err;
    end
    if (pkt_abort) n_abort++;
    chk("rd_gate", read_enb && !(valid_out && sink_ready && !sft_rst), 1'b0);
    chk("rd_hold", read_enb && (bubble || no_read), 1'b0);
    bubble = 0;
    if (exp_done || exp_abort) begin
      no_read         = 0;
      last_idle_cycle = cycle;
    end
    if (read_enb) begin
      rd_cycles.push_back(cycle);
      if (rd_pos == 0) begin
        chk("start_delay", (cycle - last_idle_cycle) >= SD + 1, 1'b1);
        bubble = 1;
        rd_pos = 1;
      end else begin
        rd_pos++;
        if (rd_pos == rd_total) begin
          no_read = 1;
          rd_pos  = 0;
        end
      end
    end
  endtask

  task automatic step();
    bit e_rst, e_rd, e_sft, busy;
    e_rst = rst;
    e_rd  = read_enb;
    e_sft = sft_rst;
    busy  = (rd_pos > 0) || (pos > 0) || no_read || bubble;
    @(posedge clk);
    #1;
    cycle++;
    if (e_rd && fifo.size() > 0) begin
      data_out = fifo.pop_front();
      last_pop = data_out;
    end else begin
      data_out = 8'($urandom_range(0, 255));
    end
    if (!e_rst) begin
      fifo.delete();
      exp_valid = 0; exp_done = 0; exp_abort = 0; done_pend = 0;
      pos = 0; rd_pos = 0; bubble = 0; no_read = 0;
      exp_pkt = 0; exp_errc = 0;
      last_idle_cycle = cycle;
    end else begin
      exp_valid = e_rd;
      exp_abort = e_sft && busy;
      exp_done  = done_pend && !e_sft;
      exp_err_v = err_pend;
      done_pend = 0;
      if (e_sft) begin
        fifo.delete();
        pos = 0; rd_pos = 0; bubble = 0; no_read = 0;
      end
      if (exp_done) begin
        exp_pkt = sat255(exp_pkt);
        if (exp_err_v) exp_errc = sat255(exp_errc);
      end
    end
    rst        = rst_req;
    sft_rst    = sft_req;
    sft_req    = 0;
    sink_ready = sr_low ? 1'b0 : ($urandom_range(1, 100) <= sr_pct);
    valid_out  = (fifo.size() > 0) && ($urandom_range(1, 100) <= gate_pct);
    #1;
    compare();
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    chk("wait_done_budget", n_done >= target, 1'b1);
  endtask

  task automatic wait_valid(input int target, input int budget);
    int k = 0;
    while (n_valid < target && k < budget) begin
      step();
      k++;
    end
    chk("wait_valid_budget", n_valid >= target, 1'b1);
  endtask

  task automatic push_pkt(input int len, input logic [1:0] addr, input bit bad);
    logic [7:0] h, b, x;
    h = {6'(len), addr};
    fifo.push_back(h);
    x = h;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      fifo.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    fifo.push_back(x);
  endtask

  initial begin
    int c0, d0, ab0, hi, k;
    rst = 0; sft_rst = 0; sink_ready = 0; valid_out = 0; data_out = 8'h00;
    rst_req = 0; sft_req = 0; sr_low = 0; gate_pct = 100; sr_pct = 100;
    cycle = 0; last_idle_cycle = 0; n_valid = 0; n_done = 0; n_abort = 0;
    pos = 0; rd_pos = 0; rd_total = 0; cur_len = 0; bubble = 0; no_read = 0;
    exp_pkt = 0; exp_errc = 0; done_pend = 0; err_pend = 0;

    // reset state
    repeat (3) step();
    chk("rst_read_enb", read_enb, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_pkt_abort", pkt_abort, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 8'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    rst_req = 1;
    repeat (2) step();

    // len 3 packet, good parity
    rd_cycles.delete();
    fifo.push_back(8'h0C); fifo.push_back(8'h11); fifo.push_back(8'h22);
    fifo.push_back(8'h33); fifo.push_back(8'h0C);
    c0 = cycle + 1;
    wait_done(n_done + 1, 60);
    chk("t2_reads", rd_cycles.size(), 5);
    for (int i = 0; i < rd_cycles.size() && i < 5; i++)
      chk("t2_rd_offset", rd_cycles[i] - c0, t2_off[i]);
    chk("t2_done_offset", done_cycle - c0, 10);
    chk("t2_parity_err", last_err, 1'b0);
    chk("t2_pkt_cnt", pkt_cnt, 8'd1);

    // same packet, bad parity
    fifo.push_back(8'h0C); fifo.push_back(8'h11); fifo.push_back(8'h22);
    fifo.push_back(8'h33); fifo.push_back(8'hFF);
    wait_done(n_done + 1, 60);
    chk("t3_parity_err", last_err, 1'b1);
    chk("t3_err_cnt", err_cnt, 8'd1);
    chk("t3_pkt_cnt", pkt_cnt, 8'd2);

    // len 0 packet
    rd_cycles.delete();
    n_valid = 0;
    fifo.push_back(8'h01); fifo.push_back(8'h01);
    c0 = cycle + 1;
    wait_done(n_done + 1, 60);
    chk("t4_reads", rd_cycles.size(), 2);
    for (int i = 0; i < rd_cycles.size() && i < 2; i++)
      chk("t4_rd_offset", rd_cycles[i] - c0, t4_off[i]);
    chk("t4_done_offset", done_cycle - c0, 7);
    chk("t4_bytes", n_valid, 2);
    chk("t4_parity_err", last_err, 1'b0);

    // len 5, sink stall after byte 2
    n_valid = 0;
    push_pkt(5, 2'd2, 1'b0);
    wait_valid(2, 40);
    sr_low = 1;
    hi = 0;
    repeat (10) begin
      step();
      if (read_enb) hi++;
    end
    chk("t5_stall_reads", hi, 0);
    sr_low = 0;
    wait_done(n_done + 1, 60);
    chk("t5_bytes", n_valid, 7);
    chk("t5_parity_err", last_err, 1'b0);
    chk("t5_pkt_cnt", pkt_cnt, 8'd4);

    // soft reset after byte 2 of a len-10 packet
    n_valid = 0;
    push_pkt(10, 2'd0, 1'b0);
    wait_valid(2, 40);
    ab0 = n_abort;
    d0  = n_done;
    sft_req = 1;
    step();
    chk("t6_rd_in_sft", read_enb, 1'b0);
    chk("t6_valid_in_sft", pkt_valid, 1'b0);
    step();
    chk("t6_abort_pulse", pkt_abort, 1'b1);
    repeat (20) step();
    chk("t6_abort_count", n_abort - ab0, 1);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_pkt_cnt", pkt_cnt, 8'd4);

    // soft reset while idle
    ab0 = n_abort;
    sft_req = 1;
    repeat (6) step();
    chk("t7_idle_abort", n_abort - ab0, 0);

    // next packet after abort uses normal start timing
    rd_cycles.delete();
    push_pkt(1, 2'd3, 1'b0);
    c0 = cycle + 1;
    wait_done(n_done + 1, 60);
    chk("t7_first_read", (rd_cycles.size() > 0) ? rd_cycles[0] - c0 : -1, 3);

    // hard reset mid-packet
    n_valid = 0;
    push_pkt(8, 2'd1, 1'b0);
    wait_valid(3, 40);
    d0  = n_done;
    ab0 = n_abort;
    rst_req = 0;
    repeat (2) step();
    rst_req = 1;
    repeat (20) step();
    chk("t8_no_done", n_done - d0, 0);
    chk("t8_no_abort", n_abort - ab0, 0);
    chk("t8_pkt_cnt", pkt_cnt, 8'd0);
    chk("t8_err_cnt", err_cnt, 8'd0);

    // randomized traffic with valid/sink stalls and back-to-back packets
    gate_pct = 70;
    sr_pct   = 70;
    for (int b = 0; b < 15; b++) begin
      k = $urandom_range(1, 3);
      for (int p = 0; p < k; p++)
        push_pkt($urandom_range(0, 20), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      wait_done(n_done + k, 1500);
    end

    // counter saturation
    gate_pct = 100;
    sr_pct   = 100;
    for (int p = 0; p < 300; p++) begin
      fifo.push_back(8'h01);
      fifo.push_back(8'h01);
    end
    wait_done(n_done + 300, 4000);
    chk("t10_pkt_cnt_sat", pkt_cnt, 8'd255);
    for (int p = 0; p < 260; p++) begin
      fifo.push_back(8'h02);
      fifo.push_back(8'h00);
    end
    wait_done(n_done + 260, 4000);
    chk("t10_err_cnt_sat", err_cnt, 8'd255);
    chk("t10_pkt_cnt_hold", pkt_cnt, 8'd255);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
